// File: rtl/external_device_pkg.sv
// Shared definitions for the external device DMA: FSM state encoding and
// the 16-bit Galois LFSR used to fill the storage.
package external_device_pkg;

    typedef enum logic [1:0] {
        ST_REFILL,
        ST_IDLE,
        ST_FIRE,
        ST_XFER
    } state_t;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/ext_lfsr16.sv
// 16-bit Galois LFSR; loads the seed on reset and advances once per step.
module ext_lfsr16
    import external_device_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/external_device_dma.sv
// External device model: refills its block storage from an LFSR, raises a
// periodic interrupt, and serves registered block reads to a CPU/DMA master.
module external_device_dma
    import external_device_pkg::*;
#(
    parameter int          WORD_SIZE     = 16,
    parameter int          BLOCK_WORDS   = 4,
    parameter int          NUM_BLOCKS    = 3,
    parameter int          FIRE_INTERVAL = 20,
    parameter int          IRQ_HOLD      = 5,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    localparam int         OFS_W  = ($clog2(NUM_BLOCKS + 1) > 1) ? $clog2(NUM_BLOCKS + 1) : 1,
    localparam int         DATA_W = BLOCK_WORDS * WORD_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OFS_W-1:0]  offset,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              rd_err,
    output logic              interrupt,
    input  logic              int_ack,
    input  logic              xfer_done,
    output logic              busy,
    output logic [7:0]        missed_count
);

    localparam int WRD_W   = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int BLK_W   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CNT_MAX = (FIRE_INTERVAL > IRQ_HOLD) ? FIRE_INTERVAL : IRQ_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [BLK_W-1:0]  blk;
    logic [WRD_W-1:0]  wrd;
    logic [LFSR_W-1:0] lfsr_value;
    logic [DATA_W-1:0] storage [NUM_BLOCKS];
    logic              refill_last, idle_last, hold_last, rd_ok;

    ext_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (state == ST_REFILL),
        .seed  (LFSR_SEED),
        .value (lfsr_value)
    );

    assign refill_last = (blk == BLK_W'(NUM_BLOCKS - 1)) && (wrd == WRD_W'(BLOCK_WORDS - 1));
    assign idle_last   = (cnt == CNT_W'(FIRE_INTERVAL - 1));
    assign hold_last   = (cnt == CNT_W'(IRQ_HOLD - 1));
    assign rd_ok       = (state != ST_REFILL) && (offset < OFS_W'(NUM_BLOCKS));
    assign busy        = (state == ST_REFILL) || (state == ST_XFER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_REFILL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_REFILL: if (refill_last) next_state = ST_IDLE;
            ST_IDLE:   if (idle_last) next_state = ST_FIRE;
            // acknowledge takes priority over hold expiry
            ST_FIRE: begin
                if (int_ack) begin
                    next_state = ST_XFER;
                end else if (hold_last) begin
                    next_state = ST_IDLE;
                end
            end
            ST_XFER:   if (xfer_done) next_state = ST_REFILL;
            default:   next_state = ST_REFILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            blk          <= '0;
            wrd          <= '0;
            missed_count <= '0;
            interrupt    <= 1'b0;
        end else begin
            interrupt <= (next_state == ST_FIRE);
            if ((next_state != state) || ((state != ST_IDLE) && (state != ST_FIRE))) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state != ST_REFILL || refill_last) begin
                blk <= '0;
                wrd <= '0;
            end else if (wrd == WRD_W'(BLOCK_WORDS - 1)) begin
                wrd <= '0;
                blk <= blk + 1'b1;
            end else begin
                wrd <= wrd + 1'b1;
            end
            if (state == ST_FIRE && !int_ack && hold_last && missed_count != 8'hFF) begin
                missed_count <= missed_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_REFILL) begin
            storage[blk][wrd * WORD_SIZE +: WORD_SIZE] <= WORD_SIZE'(lfsr_value);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            data_valid <= rd_en && rd_ok;
            rd_err     <= rd_en && !rd_ok;
            if (rd_en && rd_ok) begin
                data <= storage[offset[BLK_W-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_external_device_dma.sv
// Bench for external_device_dma: directed scenario steps followed by random
// traffic, all compared every cycle against a phase/countdown reference model.
module tb_external_device_dma;

    localparam int          WS   = 16;
    localparam int          BW   = 4;
    localparam int          NB   = 3;
    localparam int          FI   = 20;
    localparam int          IH   = 5;
    localparam int          DW   = WS * BW;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset, rd_en, int_ack, xfer_done;
    logic [1:0]    offset;
    logic [DW-1:0] data;
    logic          data_valid, rd_err, interrupt, busy;
    logic [7:0]    missed_count;

    external_device_dma #(
        .WORD_SIZE     (WS),
        .BLOCK_WORDS   (BW),
        .NUM_BLOCKS    (NB),
        .FIRE_INTERVAL (FI),
        .IRQ_HOLD      (IH),
        .LFSR_SEED     (SEED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .offset       (offset),
        .rd_en        (rd_en),
        .data         (data),
        .data_valid   (data_valid),
        .rd_err       (rd_err),
        .interrupt    (interrupt),
        .int_ack      (int_ack),
        .xfer_done    (xfer_done),
        .busy         (busy),
        .missed_count (missed_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: phase 0=refill 1=idle 2=fire 3=xfer, with cycles left.
    // Refill contents are generated up front; reads are refused during refill.
    int            m_phase;
    int            m_left;
    int            m_missed;
    logic [15:0]   m_lfsr;
    logic [15:0]   m_mem [NB][BW];
    logic [DW-1:0] m_data;
    logic          m_valid, m_err;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic [15:0] half;
        half = v / 2;
        return (v % 2 == 1) ? (half ^ 16'hB400) : half;
    endfunction

    task automatic regen();
        for (int b = 0; b < NB; b++) begin
            for (int w = 0; w < BW; w++) begin
                m_mem[b][w] = m_lfsr;
                m_lfsr      = lfsr_adv(m_lfsr);
            end
        end
        m_phase = 0;
        m_left  = NB * BW;
    endtask

    task automatic model_edge(input logic r, input logic re, input logic [1:0] off,
                              input logic ack, input logic done);
        if (r) begin
            m_lfsr   = SEED;
            regen();
            m_data   = '0;
            m_valid  = 1'b0;
            m_err    = 1'b0;
            m_missed = 0;
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
            if (re) begin
                if (m_phase != 0 && int'(off) < NB) begin
                    for (int w = 0; w < BW; w++) m_data[w*WS +: WS] = m_mem[off][w];
                    m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            case (m_phase)
                0: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 1; m_left = FI; end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 2; m_left = IH; end
                end
                2: begin
                    if (ack) begin
                        m_phase = 3;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = 1;
                            m_left  = FI;
                            if (m_missed < 255) m_missed++;
                        end
                    end
                end
                default: if (done) regen();
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic r, input logic re, input logic [1:0] off,
                        input logic ack, input logic done);
        reset     = r;
        rd_en     = re;
        offset    = off;
        int_ack   = ack;
        xfer_done = done;
        @(posedge clk);
        model_edge(r, re, off, ack, done);
        #1;
        chk("data", data, m_data);
        chk("data_valid", DW'(data_valid), DW'(m_valid));
        chk("rd_err", DW'(rd_err), DW'(m_err));
        chk("interrupt", DW'(interrupt), DW'(m_phase == 2));
        chk("busy", DW'(busy), DW'(m_phase == 0 || m_phase == 3));
        chk("missed_count", DW'(missed_count), DW'(m_missed));
    endtask

    initial begin
        logic [DW-1:0] old_data;
        logic [DW-1:0] old2;
        int n;
        reset = 1'b1; rd_en = 1'b0; offset = '0; int_ack = 1'b0; xfer_done = 1'b0;

        tick(1, 0, 0, 0, 0);
        tick(1, 1, 2, 1, 1);
        chk("rst_interrupt", DW'(interrupt), '0);
        chk("rst_busy", DW'(busy), DW'(1));
        chk("rst_data", data, '0);
        chk("rst_missed", DW'(missed_count), '0);

        n = 0;
        do begin tick(0, 0, 0, 0, 0); n++; end while (busy && n < 100);
        chk("busy_after_release", DW'(n), DW'(12));
        tick(0, 1, 0, 0, 0); n++;
        chk("word0_valid", DW'(data_valid), DW'(1));
        chk("word0_seed", DW'(data[15:0]), DW'(16'hACE1));
        while (!interrupt && n < 200) begin tick(0, 0, 0, 0, 0); n++; end
        chk("irq_rise_cycle", DW'(n), DW'(32));

        n = 0;
        do begin tick(0, 0, 0, 0, 0); n++; end while (interrupt && n < 50);
        chk("irq_high_len", DW'(n), DW'(5));
        chk("missed_one", DW'(missed_count), DW'(1));
        n = 0;
        while (!interrupt && n < 100) begin tick(0, 0, 0, 0, 0); n++; end
        chk("irq_rerise", DW'(n), DW'(20));

        old_data = data;
        tick(0, 1, 3, 0, 0);
        chk("bad_ofs_err", DW'(rd_err), DW'(1));
        chk("bad_ofs_valid", DW'(data_valid), '0);
        chk("bad_ofs_hold", data, old_data);
        tick(0, 1, 2, 0, 0);
        chk("ofs2_valid", DW'(data_valid), DW'(1));
        old2 = data;
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("fire4_irq", DW'(interrupt), DW'(1));
        tick(0, 0, 0, 1, 0);
        chk("ack_busy", DW'(busy), DW'(1));
        chk("ack_irq", DW'(interrupt), '0);
        chk("ack_missed", DW'(missed_count), DW'(1));
        tick(0, 0, 0, 1, 0);
        chk("xfer_hold", DW'(busy), DW'(1));
        tick(0, 1, 2, 0, 1);
        chk("done_read_old", data, old2);
        chk("done_read_valid", DW'(data_valid), DW'(1));
        tick(0, 1, 0, 0, 0); n = 1;
        chk("refill_rd_err", DW'(rd_err), DW'(1));
        while (busy && n < 100) begin tick(0, 0, 0, 0, 0); n++; end
        chk("refill_len", DW'(n), DW'(12));
        tick(0, 1, 2, 0, 0);
        chk("new_data_differs", DW'(data != old2), DW'(1));

        n = 0;
        while (!interrupt && n < 100) begin tick(0, 0, 0, 0, 0); n++; end
        chk("irq_again", DW'(interrupt), DW'(1));
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        chk("in_xfer", DW'(busy), DW'(1));
        tick(1, 0, 0, 0, 1);
        chk("rst_xfer_irq", DW'(interrupt), '0);
        chk("rst_xfer_busy", DW'(busy), DW'(1));
        chk("rst_xfer_missed", DW'(missed_count), '0);

        repeat (1500) begin
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
